// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan display path.
// Segment codes are active-low {dp, g..a}; the dp bit is left high here.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running sequential double-dabble converter: 20-bit binary to 6 BCD digits.
// One conversion every 22 clocks (LOAD, 20 x SHIFT, DONE); valid pulses in DONE.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter logic [19:0] DATA_MAX = 20'd999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] bin,
  output logic [23:0] bcd,
  output logic        valid
);

  conv_state_t state, state_nxt;
  logic [4:0]  iter;
  logic [19:0] bin_sr;
  logic [23:0] bcd_sr;
  logic [23:0] bcd_adj;
  logic [43:0] shifted;

  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first guarantees every path drives state_nxt, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (iter == 5'd19) state_nxt = DONE;
      DONE:    state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Add-3 correction on every nibble that would overflow past 9 after doubling.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, bin_sr} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      iter   <= 5'd0;
      bin_sr <= 20'd0;
      bcd_sr <= 24'd0;
    end else begin
      case (state)
        LOAD: begin
          bin_sr <= (bin > DATA_MAX) ? DATA_MAX : bin;
          bcd_sr <= 24'd0;
          iter   <= 5'd0;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= shifted;
          iter             <= iter + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign bcd   = bcd_sr;
  assign valid = (state == DONE);

endmodule

// File: rtl/seg_scan_bcd.sv
// 6-digit common-anode display driver: BCD conversion, leading-zero blanking,
// minus sign, decimal points and time-multiplexed registered segment/select outputs.
module seg_scan_bcd
  import seg_pkg::*;
#(
  parameter logic [15:0] SCAN_MAX = 16'd49_999,
  parameter logic [19:0] DATA_MAX = 20'd999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] data,
  input  logic        neg,
  input  logic [5:0]  point,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  logic [23:0] conv_bcd;
  logic        conv_valid;
  logic        load_cyc;
  logic        neg_lat;
  logic [23:0] disp_bcd;
  logic        disp_neg;
  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic [5:0]  shown;
  logic [5:0]  minus_at;
  logic        seen;
  logic [3:0]  cur_nib;
  logic [7:0]  cur_code;

  bin2bcd_seq #(.DATA_MAX(DATA_MAX)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .bin   (data),
    .bcd   (conv_bcd),
    .valid (conv_valid)
  );

  // The converter is in LOAD right after reset and right after DONE; neg is latched alongside data.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cyc <= 1'b1;
      neg_lat  <= 1'b0;
      disp_bcd <= 24'd0;
      disp_neg <= 1'b0;
    end else begin
      load_cyc <= conv_valid;
      if (load_cyc) neg_lat <= neg;
      if (conv_valid) begin
        disp_bcd <= conv_bcd;
        disp_neg <= neg_lat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= 16'd0;
      digit_idx <= 3'd0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt  <= 16'd0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + 16'd1;
    end
  end

  // A digit is shown once any digit at or above it is non-zero; digit 0 is always shown.
  always_comb begin
    shown    = '0;
    minus_at = '0;
    seen     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      seen     = seen | (disp_bcd[4*i +: 4] != 4'd0);
      shown[i] = seen;
    end
    shown[0] = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      minus_at[i] = disp_neg & ~shown[i] & shown[i-1];
    end

    cur_nib = disp_bcd[{digit_idx, 2'b00} +: 4];
    if (shown[digit_idx])         cur_code = seg_decode(cur_nib);
    else if (minus_at[digit_idx]) cur_code = SEG_MINUS;
    else                          cur_code = SEG_BLANK;
    if (point[digit_idx]) cur_code[7] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || !seg_en) begin
      sel <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      sel <= ~(6'b000001 << digit_idx);
      seg <= cur_code;
    end
  end

endmodule
